// File: rtl/gf163_kmul_seq.sv
// Sequential GF(2^163) multiplier (NIST B-163): streams W-bit digit pairs through an
// external combinational carry-less core, accumulates, then folds modulo x^163+x^7+x^6+x^3+1.
module gf163_kmul_seq #(
  parameter int W = 41
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [162:0]     a,
  input  logic [162:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [162:0]     c,
  output logic             busy,
  output logic [W-1:0]     core_a,
  output logic [W-1:0]     core_b,
  input  logic [2*W-2:0]   core_c
);

  localparam int N  = (163 + W - 1) / W;
  localparam int NW = N * W;
  localparam int AW = 2 * NW - 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, MUL, REDUCE, DONE} state_t;

  state_t          r_state;
  logic [NW-1:0]   r_a;
  logic [NW-1:0]   r_b;
  logic [AW-1:0]   r_acc;
  logic [IW-1:0]   r_i;
  logic [IW-1:0]   r_j;
  logic            r_red;

  logic [W-1:0]    w_da;
  logic [W-1:0]    w_db;
  logic [AW-1:0]   w_pp;
  logic [AW-1:0]   w_fold;

  // One modular fold: x^163 == x^7 + x^6 + x^3 + 1, applied to everything above bit 162.
  function automatic logic [AW-1:0] fold163(input logic [AW-1:0] x);
    logic [AW-1:0] h;
    h = x >> 163;
    return (x & AW'({163{1'b1}})) ^ h ^ (h << 3) ^ (h << 6) ^ (h << 7);
  endfunction

  assign w_da   = W'(r_a >> (int'(r_i) * W));
  assign w_db   = W'(r_b >> (int'(r_j) * W));
  assign w_pp   = AW'(core_c) << (W * (int'(r_i) + int'(r_j)));
  assign w_fold = fold163(r_acc);

  assign core_a   = (r_state == MUL) ? w_da : '0;
  assign core_b   = (r_state == MUL) ? w_db : '0;
  assign in_ready = (r_state == IDLE);
  assign busy     = (r_state == MUL) || (r_state == REDUCE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_red     <= 1'b0;
      out_valid <= 1'b0;
      c         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= NW'(a);
            r_b     <= NW'(b);
            r_acc   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_red   <= 1'b0;
            r_state <= MUL;
          end
        end
        MUL: begin
          r_acc <= r_acc ^ w_pp;
          if (r_j == LAST) begin
            r_j <= '0;
            if (r_i == LAST) r_state <= REDUCE;
            else             r_i     <= r_i + IW'(1);
          end else begin
            r_j <= r_j + IW'(1);
          end
        end
        REDUCE: begin
          // Second fold leaves degree < 163, so its output is the final residue.
          r_acc <= w_fold;
          r_red <= 1'b1;
          if (r_red) begin
            c         <= w_fold[162:0];
            out_valid <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
